// File: rtl/img_pkg.sv
// Shared image geometry, controller state encoding and rotation select codes
// for the frame rotation datapath.
package img_pkg;

    localparam int IMG_W   = 256;
    localparam int ADDR_SZ = 16;

    // IDLE: waiting for start | LOAD: writing raster input | DRAIN: rotated readout | DONE: frame_done pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_t;

endpackage

// File: rtl/rot_addr_gen.sv
// Maps an output raster coordinate (ox, oy) to the source pixel address {y, x}
// for the selected clockwise rotation. Purely combinational.
module rot_addr_gen #(
    parameter int CW = 8
) (
    input  logic [CW-1:0]   ox,
    input  logic [CW-1:0]   oy,
    input  logic [1:0]      rot,
    output logic [2*CW-1:0] addr
);
    import img_pkg::*;

    // MAX - n wraps modulo 2^CW, matching the square power-of-two frame.
    localparam logic [CW-1:0] MAX = '1;

    always_comb begin
        addr = {oy, ox};
        case (rot)
            ROT_0:   addr = {oy, ox};
            ROT_90:  addr = {MAX - ox, oy};
            ROT_180: addr = {MAX - oy, MAX - ox};
            ROT_270: addr = {ox, MAX - oy};
            default: addr = {oy, ox};
        endcase
    end

endmodule

// File: rtl/rotate_frame_ctrl.sv
// Frame rotation controller: loads a raster frame into external SRAM, then
// reads it back in rotated order through a 2-entry output FIFO.
module rotate_frame_ctrl #(
    parameter int IMG_W   = img_pkg::IMG_W,
    parameter int ADDR_SZ = img_pkg::ADDR_SZ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         rot_sel,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_SZ-1:0] mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    output logic               busy,
    output logic               frame_done
);
    import img_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [CW-1:0]   x_nx, y_nx;
    logic [1:0]      rot_q, rot_d;
    logic            rd_done_q, rd_done_d;
    logic            infl_q, infl_d;
    logic [7:0]      fifo_q [2];
    logic [7:0]      fifo_d [2];
    logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [2*CW-1:0] rd_addr;
    logic [2:0]      occ;
    logic            last_xy, pop, rd_issue, room;

    rot_addr_gen #(.CW(CW)) u_rot_addr_gen (
        .ox   (x_q),
        .oy   (y_q),
        .rot  (rot_q),
        .addr (rd_addr)
    );

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign pop       = out_valid && out_ready;
    assign last_xy   = (x_q == CMAX) && (y_q == CMAX);
    assign x_nx      = (x_q == CMAX) ? '0 : x_q + CW'(1);
    assign y_nx      = (x_q == CMAX) ? y_q + CW'(1) : y_q;

    // A slot freed by this cycle's pop counts as room, which keeps the
    // read pipe full at one pixel per cycle without ever overfilling.
    assign occ  = {1'b0, cnt_q} + {2'b00, infl_q};
    assign room = occ < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        rot_d      = rot_q;
        rd_done_d  = rd_done_q;
        rd_issue   = 1'b0;
        in_ready   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    rot_d     = rot_sel;
                    x_d       = '0;
                    y_d       = '0;
                    rd_done_d = 1'b0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ADDR_SZ'({y_q, x_q});
                    mem_wdata = in_data;
                    x_d       = x_nx;
                    y_d       = y_nx;
                    if (last_xy) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_done_q && room) begin
                    rd_issue = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = ADDR_SZ'(rd_addr);
                    x_d      = x_nx;
                    y_d      = y_nx;
                    if (last_xy) rd_done_d = 1'b1;
                end
                // Everything issued and landed, one pixel left: this pop ends the frame.
                if (pop && rd_done_q && !infl_q && (cnt_q == 2'd1)) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        infl_d = rd_issue;
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (infl_q) begin
            fifo_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            rot_q     <= '0;
            rd_done_q <= 1'b0;
            infl_q    <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rot_q     <= rot_d;
            rd_done_q <= rd_done_d;
            infl_q    <= infl_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fifo_q    <= fifo_d;
        end
    end

endmodule

// File: tb/tb_rotate_frame_ctrl.sv
// Bench for rotate_frame_ctrl on a 16x16 frame: an SRAM model, an image
// rotation reference model and a per-cycle output checker.
module tb_rotate_frame_ctrl;
    localparam int W        = 16;
    localparam int AW       = 8;
    localparam int N        = W * W;
    localparam int ABORT_AT = 117;   // same fraction of the frame as 30000/65536

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    rot_sel = 2'd0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'd0;
    logic          busy, frame_done;

    logic [7:0] sram [N];

    int checks = 0;
    int failures = 0;
    int img [N];
    int exp_img [N];
    bit chk_en = 1'b0;
    bit rand_ready = 1'b0;
    int out_idx = 0;
    int done_cnt = 0;
    int first_out = -1;
    int last_out = -1;

    rotate_frame_ctrl #(.IMG_W(W), .ADDR_SZ(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .rot_sel(rot_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    // Reference: rotate the source image clockwise by 90 degrees 'rot' times.
    task automatic prep(input int rot, input int kind);
        int a [N];
        int b [N];
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       img[i] = ((i % W) + (i / W)) & 255;
                1:       img[i] = i;
                default: img[i] = int'($urandom_range(0, 255));
            endcase
            a[i] = img[i];
        end
        for (int k = 0; k < rot; k++) begin
            for (int r = 0; r < W; r++)
                for (int c = 0; c < W; c++)
                    b[r * W + c] = a[(W - 1 - c) * W + r];
            a = b;
        end
        exp_img   = a;
        out_idx   = 0;
        done_cnt  = 0;
        first_out = -1;
        last_out  = -1;
    endtask

    task automatic start_load(input int rot, input bit gaps, input bit poke);
        int i = 0;
        int guard = 0;
        chk_en  = 1'b1;
        start   = 1'b1;
        rot_sel = 2'(rot);
        @(posedge clk); #1;
        start = 1'b0;
        while (i < N && guard < 8 * N) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = 8'(img[i]);
            end
            if (poke && i == N / 2) begin
                start   = 1'b1;
                rot_sel = 2'(rot + 1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check(i == N, "load_count", i, N);
    endtask

    task automatic drain(input bit rrdy, input bit poke);
        int cyc = 0;
        int lat = -1;
        rand_ready = rrdy;
        @(negedge clk);
        check(!in_ready, "in_ready_in_drain", int'(in_ready), 0);
        while (!frame_done && cyc < 20 * N) begin
            if (out_valid && lat < 0) lat = cyc;
            @(negedge clk);
            cyc++;
        end
        check(frame_done, "frame_done_seen", int'(frame_done), 1);
        check(lat == 2, "first_valid_latency", lat, 2);
        if (!rrdy) check(cyc == N + 2, "drain_cycles", cyc, N + 2);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!busy, "idle_after_frame", int'(busy), 0);
        check(done_cnt == 1, "frame_done_count", done_cnt, 1);
        check(out_idx == N, "output_total", out_idx, N);
        chk_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs();
        check(!in_ready, "rst_in_ready", int'(in_ready), 0);
        check(!out_valid, "rst_out_valid", int'(out_valid), 0);
        check(!busy, "rst_busy", int'(busy), 0);
        check(!frame_done, "rst_frame_done", int'(frame_done), 0);
        check(!mem_en, "rst_mem_en", int'(mem_en), 0);
        check(!mem_we, "rst_mem_we", int'(mem_we), 0);
        check(mem_addr == '0, "rst_mem_addr", int'(mem_addr), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle output checker against the reference model.
    initial begin
        bit stall_prev = 1'b0;
        bit last_pop_prev = 1'b0;
        int stall_data = 0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                stall_prev    = 1'b0;
                last_pop_prev = 1'b0;
            end else begin
                if (frame_done) begin
                    done_cnt++;
                    check(last_pop_prev, "done_after_last_accept", int'(last_pop_prev), 1);
                end
                if (stall_prev)
                    check(out_valid && int'(out_data) == stall_data, "stall_hold",
                          int'(out_data), stall_data);
                last_pop_prev = 1'b0;
                if (out_valid && out_ready) begin
                    check(out_idx < N, "output_count", out_idx, N - 1);
                    if (out_idx < N) begin
                        check(int'(out_data) == exp_img[out_idx], "out_data",
                              int'(out_data), exp_img[out_idx]);
                        if (out_idx == 0) first_out = int'(out_data);
                        last_out      = int'(out_data);
                        last_pop_prev = (out_idx == N - 1);
                    end
                    out_idx++;
                end
                stall_prev = out_valid && !out_ready;
                stall_data = int'(out_data);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;

        prep(0, 0);
        start_load(0, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        check(exp_img[N - 1] == 30, "model_ramp_last", exp_img[N - 1], 30);
        check(first_out == 0, "rot0_first", first_out, 0);
        check(last_out == 30, "rot0_last", last_out, 30);

        prep(1, 1);
        start_load(1, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        check(exp_img[0] == 240, "model_rot90_first", exp_img[0], 240);
        check(first_out == 240, "rot90_first", first_out, 240);

        prep(2, 1);
        start_load(2, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        check(exp_img[0] == 255, "model_rot180_first", exp_img[0], 255);
        check(first_out == 255, "rot180_first", first_out, 255);

        prep(3, 1);
        start_load(3, 1'b0, 1'b1);
        drain(1'b0, 1'b1);
        check(exp_img[0] == 15, "model_rot270_first", exp_img[0], 15);
        check(exp_img[1] == 31, "model_rot270_second", exp_img[1], 31);
        check(first_out == 15, "rot270_first", first_out, 15);

        prep(1, 2);
        start_load(1, 1'b1, 1'b1);
        drain(1'b1, 1'b1);

        prep(2, 1);
        start_load(2, 1'b0, 1'b0);
        guard = 0;
        while (out_idx < ABORT_AT && guard < 4 * N) begin
            @(posedge clk);
            guard++;
        end
        check(out_idx >= ABORT_AT, "abort_point_reached", out_idx, ABORT_AT);
        #1;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk_reset_outputs();
        check(done_cnt == 0, "abort_no_done", done_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        prep(3, 2);
        start_load(3, 1'b1, 1'b0);
        drain(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
